// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and load/store.
// Optional response watchdog is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_STARVE  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              owner_ls;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        starve_cnt;
  logic              if_win;
  logic              ls_win;
  logic              rsp_done;
  logic              rsp_to;
  logic [DATA_W-1:0] rsp_data;

  // Fetch only beats a pending LSU request once it has lost MAX_STARVE times.
  assign if_win = if_req && (!ls_req || starve_cnt == 4'(MAX_STARVE));
  assign ls_win = ls_req && !if_win;

  assign rsp_done = (state == RESP) && mem_rvalid;
  assign rsp_data = rsp_done ? mem_rdata : DATA_W'(32'hDEADBEEF);

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign rsp_to = (state == RESP) && !mem_rvalid &&
                  (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err    = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == RESP && !mem_rvalid && !rsp_to)
        wd_cnt <= wd_cnt + 1'b1;
      else
        wd_cnt <= '0;
      if (rsp_to)
        err_q <= 1'b1;
    end
  end
`else
  assign rsp_to = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    if_gnt   = 1'b0;
    ls_gnt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || ls_req)
          state_nx = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          if_gnt   = !owner_ls;
          ls_gnt   = owner_ls;
          state_nx = we_q ? IDLE : RESP;
        end
      end
      RESP: begin
        if (rsp_done || rsp_to)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign mem_we    = we_q && (state == REQ);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_ls   <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (if_win) begin
        owner_ls   <= 1'b0;
        addr_q     <= if_addr;
        we_q       <= 1'b0;
        wdata_q    <= '0;
        starve_cnt <= '0;
      end else if (ls_win) begin
        owner_ls <= 1'b1;
        addr_q   <= ls_addr;
        we_q     <= ls_we;
        wdata_q  <= ls_wdata;
        if (if_req && starve_cnt != 4'(MAX_STARVE))
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (!if_req)
        starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (rsp_done || rsp_to) begin
        if (owner_ls) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= rsp_data;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard.
// Define ARB_TIMEOUT_EN for both files to exercise the watchdog.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        err;

  logic        gnt_ok = 1'b1;
  logic        drop_rsp = 1'b0;
  logic        force_rv = 1'b0;
  logic [31:0] force_data = '0;
  logic        rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic        st_vld = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit          ls;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   gnt_log[$];

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_STARVE(4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .ls_req(ls_req),
    .ls_we(ls_we),
    .ls_addr(ls_addr),
    .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h100: return 32'h00500093;
      32'h104: return 32'h55667788;
      32'h108: return 32'h00000013;
      32'h200: return 32'h11223344;
      32'h300: return 32'hA5A50001;
      default: return 32'h0;
    endcase
  endfunction

  // Memory: grants immediately when allowed, answers reads one cycle later.
  assign mem_gnt    = mem_req & gnt_ok;
  assign mem_rvalid = rv_q | force_rv;
  assign mem_rdata  = force_rv ? force_data : rd_q;

  always @(posedge clk) begin
    rv_q <= 1'b0;
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        st_vld  <= 1'b1;
        st_addr <= mem_addr;
        st_data <= mem_wdata;
      end else if (!drop_rsp) begin
        rv_q <= 1'b1;
        rd_q <= (st_vld && st_addr == mem_addr) ? st_data : rom(mem_addr);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt) gnt_log.push_back(1'b0);
      if (ls_gnt) gnt_log.push_back(1'b1);
      if (if_rvalid || ls_rvalid) begin
        nvec++;
        if (if_rvalid && ls_rvalid) begin
          nerr++;
          $display("FAIL dual_rvalid: got both rvalid, required one");
        end else if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_rvalid: got ls=%0b data %h, required none",
                   ls_rvalid, ls_rvalid ? ls_rdata : if_rdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.ls != ls_rvalid ||
              (ls_rvalid ? ls_rdata : if_rdata) !== mon_e.data) begin
            nerr++;
            $display("FAIL rsp: got ls=%0b data %h, required ls=%0b data %h",
                     ls_rvalid, ls_rvalid ? ls_rdata : if_rdata,
                     mon_e.ls, mon_e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_if(input logic [31:0] a);
    int k = 0;
    if_addr = a;
    if_req  = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!if_gnt && k < 60);
    if (!if_gnt) chk("if_gnt_timeout", {31'b0, if_gnt}, 32'd1);
    @(posedge clk);
    #1;
    if_req = 1'b0;
  endtask

  task automatic do_ls(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    int k = 0;
    ls_we    = we;
    ls_addr  = a;
    ls_wdata = d;
    ls_req   = 1'b1;
    do begin
      @(negedge clk);
      k++;
    end while (!ls_gnt && k < 60);
    if (!ls_gnt) chk("ls_gnt_timeout", {31'b0, ls_gnt}, 32'd1);
    @(posedge clk);
    #1;
    ls_req = 1'b0;
    ls_we  = 1'b0;
  endtask

  task automatic drain(input string n);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(n, exp_q.size(), 32'd0);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    bit pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int k;

    repeat (3) @(posedge clk);
    smp();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_gnt", {30'b0, if_gnt, ls_gnt}, 32'd0);
    chk("rst_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // single fetch with exact latency
    exp_q.push_back('{1'b0, 32'h00500093});
    if_addr = 32'h100;
    if_req  = 1'b1;
    smp();
    chk("t1_c0_mem_req", {31'b0, mem_req}, 32'd0);
    smp();
    chk("t1_c1_if_gnt", {31'b0, if_gnt}, 32'd1);
    chk("t1_c1_mem_addr", mem_addr, 32'h100);
    chk("t1_c1_mem_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    if_req = 1'b0;
    smp();
    chk("t1_c2_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    smp();
    chk("t1_c3_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk("t1_c3_if_rdata", if_rdata, 32'h00500093);
    tick();

    // simultaneous requests: load first, then fetch
    gnt_log.delete();
    exp_q.push_back('{1'b1, 32'h11223344});
    exp_q.push_back('{1'b0, 32'h55667788});
    fork
      do_if(32'h104);
      do_ls(1'b0, 32'h200, 32'h0);
    join
    drain("t2_drain");
    chk("t2_ngnt", gnt_log.size(), 32'd2);
    if (gnt_log.size() == 2) begin
      chk("t2_first_ls", {31'b0, gnt_log[0]}, 32'd1);
      chk("t2_second_if", {31'b0, gnt_log[1]}, 32'd0);
    end

    // starvation: 4 LSU wins then one fetch, twice
    gnt_log.delete();
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back('{1'b1, 32'hA5A50001});
      exp_q.push_back('{1'b0, 32'h00000013});
    end
    if_addr = 32'h108;
    ls_addr = 32'h300;
    ls_we   = 1'b0;
    if_req  = 1'b1;
    ls_req  = 1'b1;
    k = 0;
    while (gnt_log.size() < 10 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    if_req = 1'b0;
    ls_req = 1'b0;
    drain("t3_drain");
    chk("t3_ngnt", gnt_log.size(), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < gnt_log.size())
        chk($sformatf("t3_gnt%0d", i), {31'b0, gnt_log[i]}, {31'b0, pat[i]});

    // store held until grant, no read response
    gnt_ok   = 1'b0;
    ls_we    = 1'b1;
    ls_addr  = 32'h40;
    ls_wdata = 32'hCAFEF00D;
    ls_req   = 1'b1;
    smp();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t4_mem_req", {31'b0, mem_req}, 32'd1);
      chk("t4_mem_we", {31'b0, mem_we}, 32'd1);
      chk("t4_mem_addr", mem_addr, 32'h40);
      chk("t4_mem_wdata", mem_wdata, 32'hCAFEF00D);
      chk("t4_ls_gnt_wait", {31'b0, ls_gnt}, 32'd0);
    end
    @(posedge clk);
    #1;
    gnt_ok = 1'b1;
    smp();
    chk("t4_ls_gnt", {31'b0, ls_gnt}, 32'd1);
    @(posedge clk);
    #1;
    ls_req = 1'b0;
    ls_we  = 1'b0;
    smp();
    chk("t4_idle_after", {31'b0, mem_req}, 32'd0);
    repeat (4) tick();
    exp_q.push_back('{1'b1, 32'hCAFEF00D});
    do_ls(1'b0, 32'h40, 32'h0);
    drain("t4_readback");

    // reset while waiting for the response
    drop_rsp = 1'b1;
    do_ls(1'b0, 32'h200, 32'h0);
    rst = 1'b1;
    smp();
    chk("t5_mem_req", {31'b0, mem_req}, 32'd0);
    chk("t5_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
    chk("t5_ls_rdata", ls_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    drop_rsp   = 1'b0;
    force_data = 32'h12345678;
    force_rv   = 1'b1;
    tick();
    force_rv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("t5_no_rvalid", {30'b0, if_rvalid, ls_rvalid}, 32'd0);
    end
    chk("t5_ls_rdata_kept", ls_rdata, 32'd0);
    tick();

`ifdef ARB_TIMEOUT_EN
    // response watchdog
    drop_rsp = 1'b1;
    exp_q.push_back('{1'b1, 32'hDEADBEEF});
    do_ls(1'b0, 32'h300, 32'h0);
    k = 0;
    do begin
      smp();
      k++;
    end while (!ls_rvalid && k < 40);
    chk("t6_latency", k, 32'd17);
    chk("t6_rdata", ls_rdata, 32'hDEADBEEF);
    chk("t6_err", {31'b0, err}, 32'd1);
    drop_rsp = 1'b0;
    tick();
    exp_q.push_back('{1'b1, 32'h11223344});
    do_ls(1'b0, 32'h200, 32'h0);
    drain("t6_drain");
    chk("t6_err_sticky", {31'b0, err}, 32'd1);
    rst = 1'b1;
    smp();
    chk("t6_err_rst", {31'b0, err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
`else
    chk("err_tied", {31'b0, err}, 32'd0);
`endif

    chk("final_queue", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
